// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the switch-bank debouncer.
//   hold_state_t : long-press tracker states, also exported on the debug bus
//   clog2_min1   : counter width for a maximum count value, never below 1 bit
//   max2         : larger of two ints, used to size the shared hold counter
package debounce_pkg;

  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_WAIT   = 2'd1,
    HOLD_REPEAT = 2'd2
  } hold_state_t;

  // Argument is "largest value + 1", so clog2_min1(n+1) bits hold 0..n.
  function automatic int clog2_min1(input int value);
    if (value <= 2) return 1;
    return $clog2(value);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch channel: 2-FF synchroniser, stability counter,
// registered rise/fall pulses and a long-press / auto-repeat tracker.
// Ports:
//   clk    in  1  system clock
//   rst_l  in  1  synchronous active-low reset, clears every register
//   raw    in  1  switch input, already polarity-corrected (1 = pressed)
//   level  out 1  debounced level
//   rise   out 1  one-cycle pulse in the cycle level first reads 1
//   fall   out 1  one-cycle pulse in the cycle level first reads 0
//   hold   out 1  one-cycle pulse on long press and on each repeat
//   state  out 2  hold tracker state (debug visibility)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 12500000,
  parameter int REPEAT_LIMIT   = 2500000
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        raw,
  output logic        level,
  output logic        rise,
  output logic        fall,
  output logic        hold,
  output hold_state_t state
);

  localparam int CW = clog2_min1(DEBOUNCE_LIMIT + 1);
  localparam int HW = clog2_min1(max2(HOLD_LIMIT, REPEAT_LIMIT) + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_END  = HW'(HOLD_LIMIT);
  localparam logic [HW-1:0] REP_END   = HW'(REPEAT_LIMIT);
  localparam logic [HW-1:0] HCNT_ONE  = HW'(1);
  localparam bit            REPEAT_EN = (REPEAT_LIMIT != 0);

  logic [1:0]    sync_q;
  logic          s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d, rise_d, fall_d;
  hold_state_t   state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          fired_q, fired_d;
  logic          hold_d;

  assign s = sync_q[1];

  // Debounce: accept s after DEBOUNCE_LIMIT consecutive samples that differ
  // from the current level; any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Hold tracker follows the level being registered this edge, so it enters
  // HOLD_WAIT on the same edge that raises rise; the first hold pulse then
  // lands exactly HOLD_LIMIT cycles after the rise cycle. A release wins over
  // an expiry in the same cycle. Without repeat, fired_q stops the saturated
  // counter from pulsing again.
  always_comb begin
    state_d = state;
    hcnt_d  = hcnt_q;
    fired_d = fired_q;
    hold_d  = 1'b0;
    if (!level_d) begin
      state_d = HOLD_IDLE;
      hcnt_d  = '0;
      fired_d = 1'b0;
    end else begin
      case (state)
        HOLD_IDLE: begin
          state_d = HOLD_WAIT;
          hcnt_d  = HCNT_ONE;
        end
        HOLD_WAIT: begin
          if (hcnt_q == HOLD_END) begin
            if (REPEAT_EN) begin
              hold_d  = 1'b1;
              state_d = HOLD_REPEAT;
              hcnt_d  = HCNT_ONE;
            end else begin
              hold_d  = ~fired_q;
              fired_d = 1'b1;
            end
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        HOLD_REPEAT: begin
          if (hcnt_q == REP_END) begin
            hold_d = 1'b1;
            hcnt_d = HCNT_ONE;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: begin
          state_d = HOLD_IDLE;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      state   <= HOLD_IDLE;
      hcnt_q  <= '0;
      fired_q <= 1'b0;
      hold    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
      state   <= state_d;
      hcnt_q  <= hcnt_d;
      fired_q <= fired_d;
      hold    <= hold_d;
    end
  end

endmodule

// File: rtl/debounce_switch_bank.sv
// N-channel switch debouncer with edge pulses and long-press/auto-repeat.
// Ports:
//   i_Clk          in  1         system clock
//   i_Rst_L        in  1         synchronous active-low reset
//   i_Switch       in  NUM_CH    raw asynchronous switch pins
//   o_Switch       out NUM_CH    debounced level (1 = pressed)
//   o_Rise         out NUM_CH    one-cycle pulse on debounced press
//   o_Fall         out NUM_CH    one-cycle pulse on debounced release
//   o_Hold         out NUM_CH    one-cycle pulse on long press / repeat
//   hold_state_dbg out 2*NUM_CH  per-channel hold tracker state, ch i at [2i+1:2i]
module debounce_switch_bank
  import debounce_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 12500000,
  parameter int REPEAT_LIMIT   = 2500000,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [NUM_CH-1:0]     i_Switch,
  output logic [NUM_CH-1:0]     o_Switch,
  output logic [NUM_CH-1:0]     o_Rise,
  output logic [NUM_CH-1:0]     o_Fall,
  output logic [NUM_CH-1:0]     o_Hold,
  output logic [2*NUM_CH-1:0]   hold_state_dbg
);

  // Normalise polarity so every channel sees 1 = pressed.
  logic [NUM_CH-1:0] pressed;
  assign pressed = i_Switch ^ {NUM_CH{ACTIVE_LOW}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hold_state_t st;

    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .HOLD_LIMIT     (HOLD_LIMIT),
      .REPEAT_LIMIT   (REPEAT_LIMIT)
    ) u_ch (
      .clk   (i_Clk),
      .rst_l (i_Rst_L),
      .raw   (pressed[i]),
      .level (o_Switch[i]),
      .rise  (o_Rise[i]),
      .fall  (o_Fall[i]),
      .hold  (o_Hold[i]),
      .state (st)
    );

    assign hold_state_dbg[2*i +: 2] = st;
  end

endmodule

// File: tb/tb_debounce_switch_bank.sv
// Directed bench for debounce_switch_bank. Three instances share the clock:
//   dut_a : repeat enabled, active-high inputs
//   dut_b : REPEAT_LIMIT = 0
//   dut_c : ACTIVE_LOW = 1
// Every pulse is an event {cycle, level, rise, fall, hold} that the stimulus
// predicts in advance; monitors pop and compare each event the DUT emits.
module tb_debounce_switch_bank;

  localparam int W = 48;

  logic clk = 1'b0;
  logic rst_a, rst_bc;
  logic [3:0] sw_a, sw_b, sw_c;
  logic [3:0] lvl_a, rise_a, fall_a, hold_a;
  logic [3:0] lvl_b, rise_b, fall_b, hold_b;
  logic [3:0] lvl_c, rise_c, fall_c, hold_c;
  logic [7:0] dbg_a, dbg_b, dbg_c;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] exp_c[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debounce_switch_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(10),
                         .REPEAT_LIMIT(3), .ACTIVE_LOW(1'b0)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_a), .i_Switch(sw_a), .o_Switch(lvl_a),
    .o_Rise(rise_a), .o_Fall(fall_a), .o_Hold(hold_a), .hold_state_dbg(dbg_a));

  debounce_switch_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(10),
                         .REPEAT_LIMIT(0), .ACTIVE_LOW(1'b0)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_bc), .i_Switch(sw_b), .o_Switch(lvl_b),
    .o_Rise(rise_b), .o_Fall(fall_b), .o_Hold(hold_b), .hold_state_dbg(dbg_b));

  debounce_switch_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(10),
                         .REPEAT_LIMIT(3), .ACTIVE_LOW(1'b1)) dut_c (
    .i_Clk(clk), .i_Rst_L(rst_bc), .i_Switch(sw_c), .o_Switch(lvl_c),
    .o_Rise(rise_c), .o_Fall(fall_c), .o_Hold(hold_c), .hold_state_dbg(dbg_c));

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input int c, input logic [3:0] lv,
                                      input logic [3:0] r, input logic [3:0] f,
                                      input logic [3:0] h);
    logic [31:0] cc;
    cc = c;
    return {cc, lv, r, f, h};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, then step just past the edge to drive/sample.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if ((rise_a | fall_a | hold_a) != 4'b0000) begin
      if (exp_a.size() == 0) chk("a_unexpected_event", ev(cyc, lvl_a, rise_a, fall_a, hold_a), '0);
      else chk("a_event", ev(cyc, lvl_a, rise_a, fall_a, hold_a), exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if ((rise_b | fall_b | hold_b) != 4'b0000) begin
      if (exp_b.size() == 0) chk("b_unexpected_event", ev(cyc, lvl_b, rise_b, fall_b, hold_b), '0);
      else chk("b_event", ev(cyc, lvl_b, rise_b, fall_b, hold_b), exp_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if ((rise_c | fall_c | hold_c) != 4'b0000) begin
      if (exp_c.size() == 0) chk("c_unexpected_event", ev(cyc, lvl_c, rise_c, fall_c, hold_c), '0);
      else chk("c_event", ev(cyc, lvl_c, rise_c, fall_c, hold_c), exp_c.pop_front());
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int t;
    int r;
    logic [7:0] bounce;

    rst_a  = 1'b0;
    rst_bc = 1'b0;
    sw_a   = 4'b0000;
    sw_b   = 4'b0000;
    sw_c   = 4'b1111;
    tick(3);

    // Reset state
    chk("reset_lvl_a", 64'(lvl_a), 64'h0);
    chk("reset_pulses_a", 64'({rise_a, fall_a, hold_a}), 64'h0);
    chk("reset_dbg_a", 64'(dbg_a), 64'h0);
    chk("reset_lvl_b", 64'(lvl_b), 64'h0);
    chk("reset_lvl_c", 64'(lvl_c), 64'h0);

    rst_a  = 1'b1;
    rst_bc = 1'b1;

    // Clean press on ch0, released before a hold can fire
    t = cyc;
    sw_a[0] = 1'b1;
    exp_a.push_back(ev(t + 6, 4'b0001, 4'b0001, 4'b0000, 4'b0000));
    exp_a.push_back(ev(t + 10, 4'b0000, 4'b0000, 4'b0001, 4'b0000));
    tick(4);
    sw_a[0] = 1'b0;
    tick(1);
    chk("press_latency_lvl_t5", 64'(lvl_a), 64'h0);
    tick(1);
    chk("press_latency_lvl_t6", 64'(lvl_a), 64'h1);
    tick(10);

    // Bounce on ch1: the single 0 lands just before acceptance
    t = cyc;
    bounce = 8'b1111_0111;
    exp_a.push_back(ev(t + 10, 4'b0010, 4'b0010, 4'b0000, 4'b0000));
    exp_a.push_back(ev(t + 16, 4'b0000, 4'b0000, 4'b0010, 4'b0000));
    for (int i = 0; i < 8; i++) begin
      sw_a[1] = bounce[i];
      tick(1);
    end
    tick(1);
    chk("bounce_lvl_t9", 64'(lvl_a), 64'h0);
    tick(1);
    sw_a[1] = 1'b0;
    tick(12);

    // Long press with repeat on dut_a ch2; release coincides with a repeat
    // expiry so the release must win. Single long press on dut_b ch0.
    t = cyc;
    r = t + 6;
    sw_a[2] = 1'b1;
    sw_b[0] = 1'b1;
    exp_a.push_back(ev(r, 4'b0100, 4'b0100, 4'b0000, 4'b0000));
    for (int k = 0; k < 7; k++)
      exp_a.push_back(ev(r + 10 + 3 * k, 4'b0100, 4'b0000, 4'b0000, 4'b0100));
    exp_a.push_back(ev(r + 31, 4'b0000, 4'b0000, 4'b0100, 4'b0000));
    exp_b.push_back(ev(r, 4'b0001, 4'b0001, 4'b0000, 4'b0000));
    exp_b.push_back(ev(r + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
    exp_b.push_back(ev(r + 30, 4'b0000, 4'b0000, 4'b0001, 4'b0000));
    tick(30);
    sw_b[0] = 1'b0;
    tick(1);
    sw_a[2] = 1'b0;
    tick(12);

    // Reset with cnt=3 mid-press on ch3: progress discarded, re-debounce
    t = cyc;
    sw_a[3] = 1'b1;
    tick(5);
    rst_a = 1'b0;
    tick(1);
    rst_a = 1'b1;
    chk("midreset_lvl", 64'(lvl_a), 64'h0);
    chk("midreset_rise", 64'(rise_a), 64'h0);
    chk("midreset_fall", 64'(fall_a), 64'h0);
    chk("midreset_hold", 64'(hold_a), 64'h0);
    exp_a.push_back(ev(t + 12, 4'b1000, 4'b1000, 4'b0000, 4'b0000));
    tick(5);
    chk("midreset_redebounce_t11", 64'(lvl_a), 64'h0);
    tick(1);
    chk("midreset_redebounce_t12", 64'(lvl_a), 64'h8);
    tick(2);
    sw_a[3] = 1'b0;
    exp_a.push_back(ev(t + 20, 4'b0000, 4'b0000, 4'b1000, 4'b0000));
    tick(10);

    // Active-low: all four channels pressed (driven low) together
    t = cyc;
    sw_c = 4'b0000;
    exp_c.push_back(ev(t + 6, 4'b1111, 4'b1111, 4'b0000, 4'b0000));
    exp_c.push_back(ev(t + 16, 4'b1111, 4'b0000, 4'b0000, 4'b1111));
    exp_c.push_back(ev(t + 19, 4'b1111, 4'b0000, 4'b0000, 4'b1111));
    exp_c.push_back(ev(t + 20, 4'b0000, 4'b0000, 4'b1111, 4'b0000));
    tick(14);
    sw_c = 4'b1111;
    tick(12);

    // Every predicted event must have been seen
    chk("a_events_missing", 64'(exp_a.size()), 64'h0);
    chk("b_events_missing", 64'(exp_b.size()), 64'h0);
    chk("c_events_missing", 64'(exp_c.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
